// File: rtl/fft_pkg.sv
// Fixed-point helpers shared by the FFT butterflies (radix-2 now, radix-4 later).
package fft_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int TW_W_DEF   = 16;
  localparam int GUARD_W    = 2;

  typedef struct packed {
    logic signed [63:0] val;
    logic               hit;
  } sat_t;

  function automatic int prod_w(input int data_w, input int tw_w);
    return data_w + tw_w;
  endfunction

  function automatic int round_shift(input int tw_w);
    return tw_w - 1;
  endfunction

  function automatic sat_t sat_clamp(input logic signed [63:0] value, input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_t               r;
    hi    = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo    = -(64'sd1 <<< (width - 1));
    r.hit = 1'b1;
    if (value > hi) begin
      r.val = hi;
    end else if (value < lo) begin
      r.val = lo;
    end else begin
      r.val = value;
      r.hit = 1'b0;
    end
    return r;
  endfunction

  // Packed complex words are {real, imag}; both extractors sign-extend the field.
  function automatic logic signed [63:0] cplx_re(input logic [127:0] word, input int width);
    logic [63:0] t;
    t = 64'(word >> width) << (64 - width);
    return $signed(t) >>> (64 - width);
  endfunction

  function automatic logic signed [63:0] cplx_im(input logic [127:0] word, input int width);
    logic [63:0] t;
    t = word[63:0] << (64 - width);
    return $signed(t) >>> (64 - width);
  endfunction
endpackage

// File: rtl/butterfly_r2_pipe_if.sv
// Operand/result bundle between stage memory, twiddle ROM and the radix-2 butterfly.
interface butterfly_r2_pipe_if
  import fft_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TW_W   = TW_W_DEF
);
  logic                i_valid;
  logic                o_ready;
  logic [2*DATA_W-1:0] i_A;
  logic [2*DATA_W-1:0] i_B;
  logic [2*TW_W-1:0]   i_W;
  logic                i_scale;
  logic                o_valid;
  logic                i_ready;
  logic [2*DATA_W-1:0] o_C;
  logic [2*DATA_W-1:0] o_D;
  logic                o_sat;

  modport slave (
    input  i_valid, i_A, i_B, i_W, i_scale, i_ready,
    output o_ready, o_valid, o_C, o_D, o_sat
  );

  modport master (
    output i_valid, i_A, i_B, i_W, i_scale, i_ready,
    input  o_ready, o_valid, o_C, o_D, o_sat
  );
endinterface

// File: rtl/cmplx_mult_pipe.sv
// Two-stage complex multiply P = B*W, rounded half-up back to DATA_W+2 bits.
module cmplx_mult_pipe
  import fft_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TW_W   = TW_W_DEF
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             en_i,
  input  logic                             vld_i,
  input  logic [2*DATA_W-1:0]              b_i,
  input  logic [2*TW_W-1:0]                w_i,
  output logic                             vld_o,
  output logic signed [DATA_W+GUARD_W-1:0] pr_o,
  output logic signed [DATA_W+GUARD_W-1:0] pi_o
);
  localparam int PW   = prod_w(DATA_W, TW_W);
  localparam int SUMW = PW + 1;
  localparam int SW   = DATA_W + GUARD_W;
  localparam logic signed [SUMW-1:0] RND = SUMW'(1) <<< (TW_W - 2);

  logic                     vld_p1_q;
  logic                     vld_p2_q;
  logic [2*DATA_W-1:0]      b_p1_q;
  logic [2*TW_W-1:0]        w_p1_q;
  logic signed [DATA_W-1:0] br;
  logic signed [DATA_W-1:0] bi;
  logic signed [TW_W-1:0]   wr;
  logic signed [TW_W-1:0]   wi;
  logic signed [PW-1:0]     m_rr;
  logic signed [PW-1:0]     m_ii;
  logic signed [PW-1:0]     m_ri;
  logic signed [PW-1:0]     m_ir;
  logic signed [SUMW-1:0]   pr_full;
  logic signed [SUMW-1:0]   pi_full;
  logic signed [SW-1:0]     pr_d;
  logic signed [SW-1:0]     pi_d;
  logic signed [SW-1:0]     pr_p2_q;
  logic signed [SW-1:0]     pi_p2_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else if (en_i) begin
      vld_p1_q <= vld_i;
      vld_p2_q <= vld_p1_q;
    end
  end

  // S1: operand capture
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      b_p1_q <= b_i;
      w_p1_q <= w_i;
    end
  end

  // S2: products, one extra bit for the add/sub, round then drop TW_W-1 fraction bits
  always_comb begin
    br      = DATA_W'(cplx_re(128'(b_p1_q), DATA_W));
    bi      = DATA_W'(cplx_im(128'(b_p1_q), DATA_W));
    wr      = TW_W'(cplx_re(128'(w_p1_q), TW_W));
    wi      = TW_W'(cplx_im(128'(w_p1_q), TW_W));
    m_rr    = PW'(br) * PW'(wr);
    m_ii    = PW'(bi) * PW'(wi);
    m_ri    = PW'(br) * PW'(wi);
    m_ir    = PW'(bi) * PW'(wr);
    pr_full = SUMW'(m_rr) - SUMW'(m_ii) + RND;
    pi_full = SUMW'(m_ri) + SUMW'(m_ir) + RND;
    pr_d    = SW'(pr_full >>> round_shift(TW_W));
    pi_d    = SW'(pi_full >>> round_shift(TW_W));
  end

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      pr_p2_q <= pr_d;
      pi_p2_q <= pi_d;
    end
  end

  assign vld_o = vld_p2_q;
  assign pr_o  = pr_p2_q;
  assign pi_o  = pi_p2_q;
endmodule

// File: rtl/butterfly_r2_pipe.sv
// Radix-2 DIT butterfly C = A + B*W, D = A - B*W; 3-stage pipeline with valid/ready
// backpressure, optional divide-by-2 stage scaling and saturation.
module butterfly_r2_pipe
  import fft_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TW_W   = TW_W_DEF,
  parameter int SAT_EN = 1
) (
  input logic                i_clk,
  input logic                i_rst,
  butterfly_r2_pipe_if.slave bus
);
  localparam int SW = DATA_W + GUARD_W;
  localparam logic signed [SW-1:0] ONE = SW'(1);

  logic                     en;
  logic [2*DATA_W-1:0]      a_p1_q;
  logic [2*DATA_W-1:0]      a_p2_q;
  logic                     scale_p1_q;
  logic                     scale_p2_q;
  logic                     vld_p2;
  logic signed [SW-1:0]     pr_p2;
  logic signed [SW-1:0]     pi_p2;
  logic signed [SW-1:0]     ar;
  logic signed [SW-1:0]     ai;
  logic signed [SW-1:0]     sum [4];
  sat_t                     clamp [4];
  logic signed [DATA_W-1:0] res [4];
  logic [2*DATA_W-1:0]      c_d;
  logic [2*DATA_W-1:0]      d_d;
  logic                     sat_d;
  logic [2*DATA_W-1:0]      c_p3_q;
  logic [2*DATA_W-1:0]      d_p3_q;
  logic                     sat_p3_q;
  logic                     vld_p3_q;

  // One global enable: a full output register that is not being drained freezes every stage.
  assign en          = !vld_p3_q || bus.i_ready;
  assign bus.o_ready = en;

  // S1/S2: A and scale ride alongside the multiplier stages
  always_ff @(posedge i_clk) begin
    if (en) begin
      a_p1_q     <= bus.i_A;
      scale_p1_q <= bus.i_scale;
      a_p2_q     <= a_p1_q;
      scale_p2_q <= scale_p1_q;
    end
  end

  cmplx_mult_pipe #(
    .DATA_W (DATA_W),
    .TW_W   (TW_W)
  ) u_mult (
    .clk_i (i_clk),
    .rst_i (i_rst),
    .en_i  (en),
    .vld_i (bus.i_valid),
    .b_i   (bus.i_B),
    .w_i   (bus.i_W),
    .vld_o (vld_p2),
    .pr_o  (pr_p2),
    .pi_o  (pi_p2)
  );

  // S3: add/sub at full guard width, then optional scale and clamp
  always_comb begin
    ar     = SW'(cplx_re(128'(a_p2_q), DATA_W));
    ai     = SW'(cplx_im(128'(a_p2_q), DATA_W));
    sum[0] = ar + pr_p2;
    sum[1] = ai + pi_p2;
    sum[2] = ar - pr_p2;
    sum[3] = ai - pi_p2;
    sat_d  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (scale_p2_q) sum[k] = (sum[k] + ONE) >>> 1;
      clamp[k] = sat_clamp(64'(sum[k]), DATA_W);
      res[k]   = DATA_W'(sum[k]);
      if (SAT_EN != 0) begin
        res[k] = DATA_W'(clamp[k].val);
        sat_d  = sat_d | clamp[k].hit;
      end
    end
    c_d = {res[0], res[1]};
    d_d = {res[2], res[3]};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_p3_q <= 1'b0;
      c_p3_q   <= '0;
      d_p3_q   <= '0;
      sat_p3_q <= 1'b0;
    end else if (en) begin
      vld_p3_q <= vld_p2;
      if (vld_p2) begin
        c_p3_q   <= c_d;
        d_p3_q   <= d_d;
        sat_p3_q <= sat_d;
      end
    end
  end

  assign bus.o_valid = vld_p3_q;
  assign bus.o_C     = c_p3_q;
  assign bus.o_D     = d_p3_q;
  assign bus.o_sat   = sat_p3_q;
endmodule

// File: tb/tb_butterfly_r2_pipe.sv
// Self-checking bench for butterfly_r2_pipe (DATA_W = TW_W = 16, SAT_EN = 1).
module tb_butterfly_r2_pipe;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  typedef struct packed {
    logic [31:0] c;
    logic [31:0] d;
    logic        sat;
  } exp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] w;
    logic        s;
    logic [31:0] c;
    logic [31:0] d;
    logic        sat;
  } vec_t;

  exp_t exp_q[$];

  butterfly_r2_pipe_if #(.DATA_W(16), .TW_W(16)) bus ();

  butterfly_r2_pipe #(.DATA_W(16), .TW_W(16), .SAT_EN(1)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: exact integer arithmetic on the complex values.
  function automatic exp_t ref_bfly(input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] w, input logic s);
    longint ar, ai, br, bi, wr, wi, pr, pi;
    longint v [4];
    exp_t   e;
    ar = longint'($signed(a[31:16]));
    ai = longint'($signed(a[15:0]));
    br = longint'($signed(b[31:16]));
    bi = longint'($signed(b[15:0]));
    wr = longint'($signed(w[31:16]));
    wi = longint'($signed(w[15:0]));
    pr = (br * wr - bi * wi + 16384) >>> 15;
    pi = (br * wi + bi * wr + 16384) >>> 15;
    v[0] = ar + pr;
    v[1] = ai + pi;
    v[2] = ar - pr;
    v[3] = ai - pi;
    e.sat = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (s) v[k] = (v[k] + 1) >>> 1;
      if (v[k] > 32767) begin
        v[k]  = 32767;
        e.sat = 1'b1;
      end else if (v[k] < -32768) begin
        v[k]  = -32768;
        e.sat = 1'b1;
      end
    end
    e.c = {v[0][15:0], v[1][15:0]};
    e.d = {v[2][15:0], v[3][15:0]};
    return e;
  endfunction

  function automatic logic [31:0] rand_w();
    if ($urandom_range(7) == 0) return 32'h8000_0000;
    return $urandom;
  endfunction

  task automatic drive_in(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] w, input logic s);
    bus.i_valid = v;
    bus.i_A     = a;
    bus.i_B     = b;
    bus.i_W     = w;
    bus.i_scale = s;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
    end
  endtask

  task automatic test_reset();
    bus.i_ready = 1'b0;
    drive_in(1'b0, '0, '0, '0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.o_valid); end
    checks++;
    if (bus.o_C !== 32'h0) begin errors++; $display("FAIL rst_C: got %h want 00000000", bus.o_C); end
    checks++;
    if (bus.o_D !== 32'h0) begin errors++; $display("FAIL rst_D: got %h want 00000000", bus.o_D); end
    checks++;
    if (bus.o_sat !== 1'b0) begin errors++; $display("FAIL rst_sat: got %b want 0", bus.o_sat); end
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", bus.o_ready); end
    checks++;
    if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid_after: got %b want 0", bus.o_valid); end
  endtask

  task automatic test_directed();
    vec_t tbl [6];
    tbl[0] = '{32'h4000_0000, 32'h2000_0000, 32'h7FFF_0000, 1'b0, 32'h6000_0000, 32'h2000_0000, 1'b0};
    tbl[1] = '{32'h4000_0000, 32'h2000_0000, 32'h0000_8001, 1'b0, 32'h4000_E000, 32'h4000_2000, 1'b0};
    tbl[2] = '{32'h7000_0000, 32'h7000_0000, 32'h7FFF_0000, 1'b0, 32'h7FFF_0000, 32'h0001_0000, 1'b1};
    tbl[3] = '{32'h7000_0000, 32'h7000_0000, 32'h7FFF_0000, 1'b1, 32'h7000_0000, 32'h0001_0000, 1'b0};
    tbl[4] = '{32'h0000_0000, 32'h8000_8000, 32'h8000_0000, 1'b0, 32'h7FFF_7FFF, 32'h8000_8000, 1'b1};
    tbl[5] = '{32'h0000_0000, 32'h8000_8000, 32'h8000_0000, 1'b1, 32'h4000_4000, 32'hC000_C000, 1'b0};
    for (int r = 0; r < 6; r++) begin
      int lat;
      lat = -1;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        bus.i_ready = 1'b1;
        if (k == 0) drive_in(1'b1, tbl[r].a, tbl[r].b, tbl[r].w, tbl[r].s);
        else bus.i_valid = 1'b0;
        #1;
        if (k > 0 && bus.o_valid === 1'b1) begin
          lat = k;
          break;
        end
      end
      checks++;
      if (lat != 3) begin errors++; $display("FAIL dir%0d_latency: got %0d want 3", r, lat); end
      checks++;
      if (bus.o_C !== tbl[r].c) begin errors++; $display("FAIL dir%0d_C: got %h want %h", r, bus.o_C, tbl[r].c); end
      checks++;
      if (bus.o_D !== tbl[r].d) begin errors++; $display("FAIL dir%0d_D: got %h want %h", r, bus.o_D, tbl[r].d); end
      checks++;
      if (bus.o_sat !== tbl[r].sat) begin errors++; $display("FAIL dir%0d_sat: got %b want %b", r, bus.o_sat, tbl[r].sat); end
    end
  endtask

  task automatic test_backpressure();
    bit          pat [7];
    int          sent, got, pi_idx, extra;
    logic [31:0] a, b, w, held_c, held_d;
    logic        s, hold_chk;
    exp_t        e;
    pat      = '{1, 0, 0, 1, 1, 0, 1};
    sent     = 0;
    got      = 0;
    pi_idx   = 0;
    hold_chk = 1'b0;
    held_c   = '0;
    held_d   = '0;
    exp_q.delete();
    a = $urandom; b = $urandom; w = rand_w(); s = 1'($urandom_range(1));
    for (int k = 0; k < 200 && got < 8; k++) begin
      @(negedge clk);
      if (hold_chk) begin
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_C !== held_c || bus.o_D !== held_d) begin
          errors++;
          $display("FAIL bp_hold: got v=%b C=%h D=%h want v=1 C=%h D=%h", bus.o_valid, bus.o_C, bus.o_D, held_c, held_d);
        end
      end
      bus.i_ready = pat[pi_idx % 7];
      pi_idx++;
      drive_in(sent < 8, a, b, w, s);
      #1;
      if (bus.o_valid && bus.i_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bp_extra: got C=%h D=%h want no output", bus.o_C, bus.o_D);
        end else begin
          e = exp_q.pop_front();
          if ({bus.o_C, bus.o_D, bus.o_sat} !== {e.c, e.d, e.sat}) begin
            errors++;
            $display("FAIL bp_data%0d: got C=%h D=%h sat=%b want C=%h D=%h sat=%b", got, bus.o_C, bus.o_D, bus.o_sat, e.c, e.d, e.sat);
          end
        end
        got++;
      end
      hold_chk = bus.o_valid && !bus.i_ready;
      held_c   = bus.o_C;
      held_d   = bus.o_D;
      if (bus.i_valid && bus.o_ready) begin
        exp_q.push_back(ref_bfly(a, b, w, s));
        sent++;
        a = $urandom; b = $urandom; w = rand_w(); s = 1'($urandom_range(1));
      end
    end
    extra = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
      #1;
      if (bus.o_valid) extra++;
    end
    checks++;
    if (got != 8) begin errors++; $display("FAIL bp_count: got %0d want 8", got); end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL bp_dup: got %0d extra outputs want 0", extra); end
  endtask

  task automatic test_throughput();
    int          sent, got, last_k, rdy_bad;
    logic [31:0] a, b, w;
    logic        s;
    exp_t        e;
    sent    = 0;
    got     = 0;
    last_k  = -1;
    rdy_bad = 0;
    exp_q.delete();
    a = $urandom; b = $urandom; w = rand_w(); s = 1'($urandom_range(1));
    for (int k = 0; k < 140 && got < 100; k++) begin
      @(negedge clk);
      bus.i_ready = 1'b1;
      drive_in(sent < 100, a, b, w, s);
      #1;
      if (bus.o_ready !== 1'b1) rdy_bad++;
      if (bus.o_valid && bus.i_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tp_extra: got C=%h D=%h want no output", bus.o_C, bus.o_D);
        end else begin
          e = exp_q.pop_front();
          if ({bus.o_C, bus.o_D, bus.o_sat} !== {e.c, e.d, e.sat}) begin
            errors++;
            $display("FAIL tp_data%0d: got C=%h D=%h sat=%b want C=%h D=%h sat=%b", got, bus.o_C, bus.o_D, bus.o_sat, e.c, e.d, e.sat);
          end
        end
        got++;
        if (got == 100) last_k = k;
      end
      if (bus.i_valid && bus.o_ready) begin
        exp_q.push_back(ref_bfly(a, b, w, s));
        sent++;
        a = $urandom; b = $urandom; w = rand_w(); s = 1'($urandom_range(1));
      end
    end
    bus.i_valid = 1'b0;
    checks++;
    if (got != 100) begin errors++; $display("FAIL tp_count: got %0d want 100", got); end
    checks++;
    if (last_k != 102) begin errors++; $display("FAIL tp_cycles: got %0d want 102", last_k); end
    checks++;
    if (rdy_bad != 0) begin errors++; $display("FAIL tp_ready: got %0d low cycles want 0", rdy_bad); end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] a, b, w;
    logic        s;
    int          stale, lat;
    exp_t        e;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.i_ready = 1'b1;
      drive_in(1'b1, $urandom, $urandom, rand_w(), 1'b0);
    end
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", bus.o_valid); end
    checks++;
    if (bus.o_C !== 32'h0 || bus.o_D !== 32'h0) begin
      errors++;
      $display("FAIL mid_data: got C=%h D=%h want 0/0", bus.o_C, bus.o_D);
    end
    @(negedge clk);
    rst         = 1'b0;
    bus.i_ready = 1'b1;
    stale       = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      if (bus.o_valid) stale++;
    end
    checks++;
    if (stale != 0) begin errors++; $display("FAIL mid_stale: got %0d outputs want 0", stale); end
    a = $urandom; b = $urandom; w = rand_w(); s = 1'b1;
    e   = ref_bfly(a, b, w, s);
    lat = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      bus.i_ready = 1'b1;
      if (k == 0) drive_in(1'b1, a, b, w, s);
      else bus.i_valid = 1'b0;
      #1;
      if (k > 0 && bus.o_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != 3) begin errors++; $display("FAIL mid_latency: got %0d want 3", lat); end
    checks++;
    if ({bus.o_C, bus.o_D, bus.o_sat} !== {e.c, e.d, e.sat}) begin
      errors++;
      $display("FAIL mid_data_new: got C=%h D=%h sat=%b want C=%h D=%h sat=%b", bus.o_C, bus.o_D, bus.o_sat, e.c, e.d, e.sat);
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.i_ready = 1'b0;
    drive_in(1'b0, '0, '0, '0, 1'b0);
    test_reset();
    idle(2);
    test_directed();
    idle(4);
    test_backpressure();
    idle(4);
    test_throughput();
    idle(4);
    test_reset_midflight();
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/butterfly_r2_pipe.md
Name: butterfly_r2_pipe

Overview:
- Parametrised, pipelined radix-2 DIT butterfly for the FFT datapath.
- Computes C = A + B·W and D = A − B·W on packed complex fixed-point words, using one twiddle per operation.
- Adds a valid/ready handshake with full backpressure, convergent-free rounding, per-stage scaling and saturation. The combinational butterfly does none of these.
- Sits between the FFT stage memory read port and the write-back port; the twiddle ROM feeds it.

Parameters:
- DATA_W, 16, width of each real/imag component of A, B, C, D; two's complement Q1.(DATA_W-1).
- TW_W, 16, width of each twiddle component; Q1.(TW_W-1).
- SAT_EN, 1, 1 = saturate results to DATA_W; 0 = wrap.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_valid  in  1  input operands valid
- o_ready  out  1  block can accept input this cycle
- i_A  in  2*DATA_W  {real, imag}, real in the upper half
- i_B  in  2*DATA_W  {real, imag}
- i_W  in  2*TW_W  twiddle {real, imag}
- i_scale  in  1  1 = divide both results by 2 (stage scaling); sampled with the operands
- o_valid  out  1  results valid
- i_ready  in  1  downstream accepts results
- o_C  out  2*DATA_W  A + B·W
- o_D  out  2*DATA_W  A − B·W
- o_sat  out  1  any component of this result pair saturated (qualified by o_valid)

Behaviour:
- Reset: pipeline valid bits and o_valid = 0; o_C, o_D, o_sat = 0; o_ready = 1 after reset deasserts. Reset mid-operation discards all in-flight data; no output appears for those operands.
- Transfer rules:
  - Input transfer occurs when i_valid && o_ready.
  - Output transfer occurs when o_valid && i_ready.
  - Pipeline enable en = !o_valid || i_ready.
  - o_ready = en. Combinational from i_ready; no combinational path from i_valid to o_ready.
- Pipeline, 3 stages, latency 3 cycles with no stall:
  - S1: register A, B, W, scale.
  - S2: four signed products Br·Wr, Bi·Wi, Br·Wi, Bi·Wr, each DATA_W+TW_W bits. Form Pr = Br·Wr − Bi·Wi and Pi = Br·Wi + Bi·Wr at DATA_W+TW_W+1 bits. Round: add 2^(TW_W-2), arithmetic shift right by TW_W-1. Hold the result at DATA_W+2 bits; do not truncate yet.
  - S3: sums at DATA_W+2 bits: Cr = Ar + Pr, Ci = Ai + Pi, Dr = Ar − Pr, Di = Ai − Pi. If scale, add 1 then arithmetic shift right by 1. Saturate each component to [−2^(DATA_W-1), 2^(DATA_W-1)−1] when SAT_EN; otherwise take the low DATA_W bits. o_sat = OR of the four per-component clamp events. Register into o_C, o_D, o_sat.
- Throughput: 1 result per cycle when i_ready is held high.
- Stall: while en = 0, all stage registers hold, including o_C, o_D and o_sat. No data is dropped or duplicated.
- Bubbles: invalid slots propagate as bubbles. Registers for bubble stages may hold stale data but their valid bit is 0.
- Simultaneous output transfer and new input: if o_valid && i_ready and the S2 slot is valid, the S2 result enters the output register in the same cycle. There is no bubble.
- Boundary case: W = (−2^(TW_W-1), 0) is legal (exactly −1). The product path must not overflow because of the extra guard bit.

Decomposition:
- Shared package fft_pkg:
  - default DATA_W and TW_W
  - localparams for product width, rounding constant and guard bits
  - functions sat_clamp(value, width) and cplx_re / cplx_im field extractors, reused by the future radix-4 block.
- One sub-module, cmplx_mult_pipe: S1/S2 complex multiply with rounding and enable input. It is instantiated once; the add/sub/scale/saturate stage stays in the top.

Test Plan (DATA_W = TW_W = 16, SAT_EN = 1):
- Basic: A = 0x4000_0000, B = 0x2000_0000, W = 0x7FFF_0000, scale 0 -> 3 cycles later o_C = 0x6000_0000, o_D = 0x2000_0000, o_sat = 0.
- −j twiddle: A = 0x4000_0000, B = 0x2000_0000, W = 0x0000_8001 -> o_C = 0x4000_E000, o_D = 0x4000_2000.
- Saturation/scale: A = B = 0x7000_0000, W = 0x7FFF_0000:
  - scale 0 -> o_C = 0x7FFF_0000, o_D = 0x0001_0000, o_sat = 1.
  - scale 1 -> o_C = 0x7000_0000, o_D = 0x0001_0000, o_sat = 0.
- Backpressure: stream 8 random vectors with i_valid held high; drive i_ready in the pattern 1,0,0,1,1,0,1… -> outputs bit-exact vs the reference model, in order, none lost or duplicated; o_C/o_D stable while o_valid && !i_ready.
- Throughput: i_ready held at 1, 100 back-to-back vectors -> 100 outputs in 102 cycles after the first, o_ready constantly 1.
- Reset mid-flight: assert i_rst asynchronously with 3 vectors in flight -> o_valid = 0 and o_C = o_D = 0 immediately; after release, the first new vector emerges 3 cycles after acceptance; no stale outputs.
